// File: rtl/l2_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : l2_arbiter_rr
// Purpose  : Arbitrates NUM_PORTS L1 requesters onto the single shared L2
//            port. Round-robin or fixed-priority selection; the winner is
//            registered and holds the L2 port until l2_resp completes its
//            transaction.
// Ports    : clk, rst_n           clock, synchronous active-low reset
//            req_read/req_write   per-port request strobes
//            req_addr/req_wdata   packed per-port address / write line
//            resp                 one-hot completion to the granted port
//            rdata                L2 read line pass-through
//            l2_address/l2_wdata  forwarded from the granted port
//            l2_read/l2_write     forwarded strobes (write wins over read)
//            l2_rdata/l2_resp     L2 return path
//            busy                 transaction in progress
//            grant_idx            currently granted port
// Revision : 1.0 - initial release
// ============================================================================
module l2_arbiter_rr #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int LINE_W    = 128,
    parameter int RR_MODE   = 1,
    localparam int IDX_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        resp,
    output logic [LINE_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           l2_address,
    output logic [LINE_W-1:0]           l2_wdata,
    output logic                        l2_read,
    output logic                        l2_write,
    input  logic [LINE_W-1:0]           l2_rdata,
    input  logic                        l2_resp,
    output logic                        busy,
    output logic [IDX_W-1:0]            grant_idx
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   grant_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_any_req;
    logic                 w_found;
    logic [IDX_W:0]       w_sum;
    logic [IDX_W-1:0]     w_cand;

    logic                 w_sel_read;
    logic                 w_sel_write;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [LINE_W-1:0]    w_sel_wdata;

    assign w_req     = req_read | req_write;
    assign w_any_req = |w_req;

    // Winner selection. Candidates are visited in priority order: from
    // rr_ptr upward with wrap in round-robin mode, from port 0 otherwise.
    // The first requesting candidate wins.
    always_comb begin
        grant_d = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (RR_MODE != 0) begin
                w_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
                if (w_sum >= (IDX_W+1)'(NUM_PORTS)) begin
                    w_sum = w_sum - (IDX_W+1)'(NUM_PORTS);
                end
                w_cand = w_sum[IDX_W-1:0];
            end else begin
                w_cand = IDX_W'(k);
            end
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                grant_d = w_cand;
            end
        end
    end

    // Next round-robin pointer: the port just after the one being released.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (RR_MODE != 0) begin
            if (grant_q == IDX_W'(NUM_PORTS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_q + IDX_W'(1);
            end
        end
    end

    // Live inputs of the granted port; other ports are locked out.
    always_comb begin
        w_sel_read  = 1'b0;
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                w_sel_read  = req_read[i];
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*LINE_W +: LINE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_any_req) begin
                        grant_q <= grant_d;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (l2_resp) begin
                        state_q  <= ST_IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state_q == ST_BUSY);
    assign grant_idx  = grant_q;
    assign rdata      = l2_rdata;
    assign l2_address = w_sel_addr;
    assign l2_wdata   = w_sel_wdata;
    // A port asserting both strobes is treated as a write.
    assign l2_write   = busy & w_sel_write;
    assign l2_read    = busy & w_sel_read & ~w_sel_write;

    always_comb begin
        resp = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            resp[i] = busy & l2_resp & (grant_q == IDX_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_arbiter_rr
// Purpose  : Self-checking bench for l2_arbiter_rr. Two instances (round-
//            robin and fixed priority) share requester stimulus; each has its
//            own l2_resp. A behavioural model per instance predicts outputs
//            every cycle; directed sequences pin the model with literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int LW = 128;
    localparam int IW = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_read;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*LW-1:0]   req_wdata;
    logic [LW-1:0]     l2_rdata;
    logic [1:0]        l2_resp;

    logic [N-1:0]      d_resp  [2];
    logic [LW-1:0]     d_rdata [2];
    logic [AW-1:0]     d_addr  [2];
    logic [LW-1:0]     d_wdata [2];
    logic              d_read  [2];
    logic              d_write [2];
    logic              d_busy  [2];
    logic [IW-1:0]     d_grant [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state: index 0 = round-robin instance, 1 = fixed priority
    int m_busy  [2];
    int m_grant [2];
    int m_ptr   [2];

    l2_arbiter_rr #(.NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp(d_resp[0]), .rdata(d_rdata[0]),
        .l2_address(d_addr[0]), .l2_wdata(d_wdata[0]),
        .l2_read(d_read[0]), .l2_write(d_write[0]),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp[0]),
        .busy(d_busy[0]), .grant_idx(d_grant[0])
    );

    l2_arbiter_rr #(.NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp(d_resp[1]), .rdata(d_rdata[1]),
        .l2_address(d_addr[1]), .l2_wdata(d_wdata[1]),
        .l2_read(d_read[1]), .l2_write(d_write[1]),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp[1]),
        .busy(d_busy[1]), .grant_idx(d_grant[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int m, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", nm, m, $time, act, exp);
        end
    endtask

    // Model: transaction-level view of the arbiter.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_busy[m]  <= 0;
                m_grant[m] <= 0;
                m_ptr[m]   <= 0;
            end else if (m_busy[m] == 0) begin
                if ((req_read | req_write) != 0) begin
                    int start;
                    int win;
                    start = (m == 0) ? m_ptr[m] : 0;
                    win = -1;
                    for (int k = 0; k < N; k++) begin
                        int p;
                        p = (start + k) % N;
                        if (win < 0 && (req_read[p] || req_write[p])) win = p;
                    end
                    m_grant[m] <= win;
                    m_busy[m]  <= 1;
                end
            end else if (l2_resp[m]) begin
                m_busy[m] <= 0;
                if (m == 0) m_ptr[m] <= (m_grant[m] + 1) % N;
            end
        end
    end

    // Per-cycle comparison against the model, just before the rising edge.
    always @(negedge clk) begin
        #4;
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                int g;
                logic e_rd, e_wr;
                logic [N-1:0] e_resp;
                g      = m_grant[m];
                e_wr   = (m_busy[m] != 0) && req_write[g];
                e_rd   = (m_busy[m] != 0) && req_read[g] && !req_write[g];
                e_resp = ((m_busy[m] != 0) && l2_resp[m]) ? (N'(1) << g) : '0;
                chk("busy", m, 128'(d_busy[m]), 128'(m_busy[m] != 0));
                chk("grant_idx", m, 128'(d_grant[m]), 128'(g));
                chk("l2_read", m, 128'(d_read[m]), 128'(e_rd));
                chk("l2_write", m, 128'(d_write[m]), 128'(e_wr));
                chk("resp", m, 128'(d_resp[m]), 128'(e_resp));
                chk("rdata", m, d_rdata[m], l2_rdata);
                if (e_rd || e_wr) chk("l2_address", m, 128'(d_addr[m]), 128'(req_addr[g*AW +: AW]));
                if (e_wr) chk("l2_wdata", m, d_wdata[m], req_wdata[g*LW +: LW]);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic samp();
        #3;
    endtask

    initial begin
        int got[$];
        int exp_rr[6];
        exp_rr = '{0, 1, 3, 0, 1, 3};

        // ---------------- reset with all requests high
        rst_n = 1'b0; req_read = '1; req_write = '1;
        req_addr = '0; req_wdata = '0; l2_rdata = '0; l2_resp = 2'b00;
        cyc(); chk_en = 1'b1;
        cyc(); samp();
        for (int m = 0; m < 2; m++) begin
            chk("rst_busy", m, 128'(d_busy[m]), 128'(0));
            chk("rst_strobes", m, 128'({d_read[m], d_write[m]}), 128'(0));
            chk("rst_resp", m, 128'(d_resp[m]), 128'(0));
            chk("rst_grant", m, 128'(d_grant[m]), 128'(0));
        end

        // ---------------- single read from port 2
        cyc(); rst_n = 1'b1; req_read = '0; req_write = '0;
        cyc(); req_read = 4'b0100; req_addr[2*AW +: AW] = 16'h1234;
        cyc(); samp();
        for (int m = 0; m < 2; m++) begin
            chk("rd_strobe", m, 128'(d_read[m]), 128'(1));
            chk("rd_addr", m, 128'(d_addr[m]), 128'(16'h1234));
            chk("rd_grant", m, 128'(d_grant[m]), 128'(2));
        end
        cyc();
        cyc(); l2_resp = 2'b11; l2_rdata = {16{8'hA5}}; samp();
        for (int m = 0; m < 2; m++) begin
            chk("rd_resp", m, 128'(d_resp[m]), 128'(4'b0100));
            chk("rd_rdata", m, d_rdata[m], {16{8'hA5}});
        end
        cyc(); req_read = '0; l2_resp = 2'b00; samp();
        for (int m = 0; m < 2; m++) begin
            chk("rd_idle", m, 128'(d_busy[m]), 128'(0));
            chk("rd_resp_off", m, 128'(d_resp[m]), 128'(0));
        end

        // ---------------- round-robin fairness / fixed priority
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1; req_read = 4'b1011; l2_resp = 2'b11;
        for (int c = 0; c < 20 && got.size() < 6; c++) begin
            cyc(); samp();
            if (d_busy[0]) got.push_back(int'(d_grant[0]));
            if (d_busy[1]) chk("fx_grant0", 1, 128'(d_grant[1]), 128'(0));
        end
        if (got.size() < 6) chk("rr_timeout", 0, 128'(got.size()), 128'(6));
        for (int i = 0; i < 6 && i < got.size(); i++) chk("rr_order", 0, 128'(got[i]), 128'(exp_rr[i]));
        cyc(); req_read = '0;
        cyc();
        cyc(); req_read = 4'b0010; l2_resp = 2'b00;
        cyc(); samp();
        chk("fx_grant1", 1, 128'({d_busy[1], d_grant[1]}), 128'({1'b1, 2'd1}));
        cyc(); req_read = '0; l2_resp = 2'b11;
        cyc(); l2_resp = 2'b00;

        // ---------------- write with lock, port 0 raises read mid-transaction
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1; req_write = 4'b0010;
        req_addr[1*AW +: AW] = 16'h0040; req_addr[0*AW +: AW] = 16'h0100;
        req_wdata[1*LW +: LW] = {8{16'hDEAD}};
        cyc(); samp();
        chk("wr_strobe", 0, 128'(d_write[0]), 128'(1));
        chk("wr_addr", 0, 128'(d_addr[0]), 128'(16'h0040));
        chk("wr_data", 0, d_wdata[0], {8{16'hDEAD}});
        cyc(); req_read = 4'b0001; samp();
        chk("lock_rw", 0, 128'({d_write[0], d_read[0]}), 128'(2'b10));
        chk("lock_addr", 0, 128'(d_addr[0]), 128'(16'h0040));
        cyc(); l2_resp = 2'b11; samp();
        chk("wr_resp", 0, 128'(d_resp[0]), 128'(4'b0010));
        cyc(); req_write = '0; l2_resp = 2'b00; samp();
        chk("wr_dead", 0, 128'(d_busy[0]), 128'(0));
        cyc(); samp();
        chk("next_grant", 0, 128'({d_busy[0], d_grant[0], d_read[0]}), 128'({1'b1, 2'd0, 1'b1}));

        // ---------------- reset mid-BUSY (rr pointer was 2 here)
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1; req_read = 4'b1010; samp();
        chk("abort_busy", 0, 128'(d_busy[0]), 128'(0));
        chk("abort_strb", 0, 128'(d_read[0]), 128'(0));
        chk("abort_resp", 0, 128'(d_resp[0]), 128'(0));
        cyc(); samp();
        chk("abort_ptr", 0, 128'({d_busy[0], d_grant[0]}), 128'({1'b1, 2'd1}));
        cyc(); req_read = '0; l2_resp = 2'b11;
        cyc();

        // ---------------- randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst_n     = ($urandom_range(0, 199) != 0);
            req_read  = N'($urandom);
            req_write = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 3) == 0) req_read = 4'b1111;
            for (int p = 0; p < N; p++) begin
                req_addr[p*AW +: AW] = AW'($urandom);
                req_wdata[p*LW +: LW] = {$urandom, $urandom, $urandom, $urandom};
            end
            l2_rdata   = {$urandom, $urandom, $urandom, $urandom};
            l2_resp[0] = ($urandom_range(0, 2) == 0);
            l2_resp[1] = ($urandom_range(0, 2) == 0);
        end

        cyc();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
